// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller.
// Edge-triggered pending capture is selected with `INTR_EDGE_EN`; level capture otherwise.
package intr_pkg;

  localparam int unsigned MAX_IRQ = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned ST_W    = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } intr_state_e;

  localparam logic [ADDR_W-1:0] INTR_IMR  = 2'd0;
  localparam logic [ADDR_W-1:0] INTR_IPR  = 2'd1;
  localparam logic [ADDR_W-1:0] INTR_STAT = 2'd2;

  localparam int unsigned PSR_IE_BIT = 3;

endpackage

// File: rtl/intr_ctrl_if.sv
// Core handshake and register port of the interrupt controller.
interface intr_ctrl_if;
  import intr_pkg::*;

  logic [DATA_W-1:0] psr;
  logic              rfi;
  logic              intr_ack;
  logic              intr_req;
  logic [ID_W-1:0]   intr_id;
  logic              intr_take;
  logic              reg_wen;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    input  psr, rfi, intr_ack, reg_wen, reg_addr, reg_wdata,
    output intr_req, intr_id, intr_take, reg_rdata
  );

  modport slave (
    output psr, rfi, intr_ack, reg_wen, reg_addr, reg_wdata,
    input  intr_req, intr_id, intr_take, reg_rdata
  );

endinterface

// File: rtl/irq_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous device lines.
module irq_sync #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: sync, pending capture, arbitration and request FSM.
// Build with `INTR_EDGE_EN` for rising-edge pending bits (W1C, cleared on accept).
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  intr_ctrl_if.master        bus
);

  localparam logic [ST_W-1:0] S_IDLE = ST_IDLE;
  localparam logic [ST_W-1:0] S_REQ  = ST_REQ;
  localparam logic [ST_W-1:0] S_SVC  = ST_SVC;

  logic [NUM_IRQ-1:0] sync;
  logic [NUM_IRQ-1:0] imr;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] elig;
  logic [MAX_IRQ-1:0] elig_wide;
  logic [ID_W-1:0]    win;
  logic [ST_W-1:0]    state, state_nx;
  logic [ID_W-1:0]    id, id_nx;
  logic               take, take_nx;
  logic               ie;
  logic               unused_bits;

  // Lowest index wins.
  function automatic logic [ID_W-1:0] prio_enc(input logic [MAX_IRQ-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  irq_sync #(.W(NUM_IRQ)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_in),
    .q     (sync)
  );

  assign ie          = bus.psr[PSR_IE_BIT];
  assign unused_bits = ^{bus.psr, bus.reg_wdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imr <= '0;
    end else if (bus.reg_wen && bus.reg_addr == INTR_IMR) begin
      imr <= bus.reg_wdata[NUM_IRQ-1:0];
    end
  end

`ifdef INTR_EDGE_EN
  logic [NUM_IRQ-1:0] sync_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] ack_clr;

  assign rise    = sync & ~sync_d;
  assign w1c     = (bus.reg_wen && bus.reg_addr == INTR_IPR) ? bus.reg_wdata[NUM_IRQ-1:0] : '0;
  assign ack_clr = take_nx ? (NUM_IRQ'(1) << id) : '0;

  // A fresh edge beats both software W1C and the accept clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_d <= '0;
      pend   <= '0;
    end else begin
      sync_d <= sync;
      pend   <= (pend & ~(w1c | ack_clr)) | rise;
    end
  end
`else
  assign pend = sync;
`endif

  assign elig      = ie ? (pend & imr) : '0;
  assign elig_wide = MAX_IRQ'(elig);
  assign win       = prio_enc(elig_wide);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      id    <= '0;
      take  <= 1'b0;
    end else begin
      state <= state_nx;
      id    <= id_nx;
      take  <= take_nx;
    end
  end

  // Request id is frozen once latched; no nesting while in service.
  always_comb begin
    state_nx = state;
    id_nx    = id;
    take_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (|elig) begin
          state_nx = S_REQ;
          id_nx    = win;
        end
      end
      S_REQ: begin
        if (bus.intr_ack) begin
          state_nx = S_SVC;
          take_nx  = 1'b1;
        end else if (!elig_wide[id]) begin
          state_nx = S_IDLE;
        end
      end
      S_SVC: begin
        if (bus.rfi) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.intr_req  = (state == S_REQ);
  assign bus.intr_id   = id;
  assign bus.intr_take = take;

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      INTR_IMR:  bus.reg_rdata = DATA_W'(imr);
      INTR_IPR:  bus.reg_rdata = DATA_W'(pend);
      INTR_STAT: bus.reg_rdata = {8'h00, id, 2'b00, state};
      default:   bus.reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl; the sequence follows the active pending mode (`INTR_EDGE_EN`).
module tb_intr_ctrl;
  import intr_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq;
  int         errors;
  int         checks;

  intr_ctrl_if bus ();

  intr_ctrl #(.NUM_IRQ(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    bus.reg_addr = addr;
    #1;
    chk(tag, bus.reg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    bus.reg_wen   = 1'b1;
    bus.reg_addr  = addr;
    bus.reg_wdata = data;
    tick(1);
    bus.reg_wen   = 1'b0;
    bus.reg_wdata = '0;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic take, input logic [3:0] id);
    chk({tag, "_req"},  16'(bus.intr_req),  16'(req));
    chk({tag, "_take"}, 16'(bus.intr_take), 16'(take));
    chk({tag, "_id"},   16'(bus.intr_id),   16'(id));
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    irq           = 8'hFF;
    bus.psr       = 16'h0000;
    bus.rfi       = 1'b0;
    bus.intr_ack  = 1'b0;
    bus.reg_wen   = 1'b0;
    bus.reg_addr  = INTR_IMR;
    bus.reg_wdata = '0;

    // Reset with all lines asserted: nothing may be captured.
    tick(3);
    chk_out("reset", 1'b0, 1'b0, 4'd0);
    chk_reg("reset_ipr",  INTR_IPR,  16'h0000);
    chk_reg("reset_imr",  INTR_IMR,  16'h0000);
    chk_reg("reset_stat", INTR_STAT, 16'h0000);
    irq = 8'h00;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    wr(INTR_IMR, 16'hFFFF);
    chk_reg("imr_upper_zero", INTR_IMR, 16'h00FF);
    wr(INTR_IMR, 16'h0004);
    chk_reg("imr_write", INTR_IMR, 16'h0004);
    bus.psr = 16'h0008;

`ifdef INTR_EDGE_EN
    // Line 2 pulsed for one cycle: pending at E2, request after E3.
    irq = 8'h04;
    tick(1);
    irq = 8'h00;
    tick(2);
    chk_reg("edge_pend_e2", INTR_IPR, 16'h0004);
    chk("edge_noreq_e2", 16'(bus.intr_req), 16'h0000);
    tick(1);
    chk_out("edge_req_e3", 1'b1, 1'b0, 4'd2);
    chk_reg("edge_stat_req", INTR_STAT, 16'h0021);

    bus.intr_ack = 1'b1;
    tick(1);
    bus.intr_ack = 1'b0;
    chk_out("edge_take", 1'b0, 1'b1, 4'd2);
    chk_reg("edge_ack_clr", INTR_IPR, 16'h0000);
    chk_reg("edge_stat_svc", INTR_STAT, 16'h0022);
    tick(1);
    chk("edge_take_once", 16'(bus.intr_take), 16'h0000);
    bus.rfi = 1'b1;
    tick(1);
    bus.rfi = 1'b0;
    tick(2);
    chk("edge_no_refire", 16'(bus.intr_req), 16'h0000);

    // Withdrawal by clearing IE, then re-issue.
    irq = 8'h04;
    tick(1);
    irq = 8'h00;
    tick(3);
    chk("wd_req", 16'(bus.intr_req), 16'h0001);
    bus.psr = 16'h0000;
    tick(1);
    chk_out("wd_idle", 1'b0, 1'b0, 4'd2);
    chk_reg("wd_pend_kept", INTR_IPR, 16'h0004);
    bus.psr = 16'h0008;
    tick(1);
    chk_out("wd_reissue", 1'b1, 1'b0, 4'd2);

    // Ack and withdrawal together: ack wins.
    bus.intr_ack = 1'b1;
    bus.psr      = 16'h0000;
    tick(1);
    bus.intr_ack = 1'b0;
    bus.psr      = 16'h0008;
    chk_out("race_ack", 1'b0, 1'b1, 4'd2);
    chk_reg("race_ack_clr", INTR_IPR, 16'h0000);
    tick(1);
    chk("race_take_once", 16'(bus.intr_take), 16'h0000);
    bus.rfi = 1'b1;
    tick(1);
    bus.rfi = 1'b0;

    // W1C and a new edge on masked line 3 in the same cycle: set wins.
    irq = 8'h08;
    tick(1);
    irq = 8'h00;
    tick(3);
    chk_reg("w1c_pre", INTR_IPR, 16'h0008);
    chk("w1c_masked_noreq", 16'(bus.intr_req), 16'h0000);
    irq = 8'h08;
    tick(1);
    irq = 8'h00;
    tick(1);
    wr(INTR_IPR, 16'h0008);
    chk_reg("w1c_race_set", INTR_IPR, 16'h0008);
    wr(INTR_IPR, 16'h0008);
    chk_reg("w1c_clear", INTR_IPR, 16'h0000);

    // Priority: lines 5 and 1 together.
    wr(INTR_IMR, 16'h00FF);
    irq = 8'h22;
    tick(1);
    irq = 8'h00;
    tick(3);
    chk_out("prio_first", 1'b1, 1'b0, 4'd1);
    bus.intr_ack = 1'b1;
    tick(1);
    bus.intr_ack = 1'b0;
    chk_reg("prio_ack_clr", INTR_IPR, 16'h0020);
    bus.rfi = 1'b1;
    tick(1);
    bus.rfi = 1'b0;
    chk("prio_gap", 16'(bus.intr_req), 16'h0000);
    tick(1);
    chk_out("prio_second", 1'b1, 1'b0, 4'd5);

    // Higher-priority line arriving in REQ does not change the id.
    irq = 8'h01;
    tick(1);
    irq = 8'h00;
    tick(3);
    chk_reg("frozen_pend", INTR_IPR, 16'h0021);
    chk_out("frozen_id", 1'b1, 1'b0, 4'd5);
`else
    // Level mode: lines 2 and 3 held, line 3 masked; request after E2.
    irq = 8'h0C;
    tick(2);
    chk("lvl_noreq_e1", 16'(bus.intr_req), 16'h0000);
    tick(1);
    chk_out("lvl_req_e2", 1'b1, 1'b0, 4'd2);
    chk_reg("lvl_stat_req", INTR_STAT, 16'h0021);
    chk_reg("lvl_ipr", INTR_IPR, 16'h000C);

    bus.intr_ack = 1'b1;
    tick(1);
    bus.intr_ack = 1'b0;
    chk_out("lvl_take", 1'b0, 1'b1, 4'd2);
    chk_reg("lvl_stat_svc", INTR_STAT, 16'h0022);
    tick(1);
    chk("lvl_take_once", 16'(bus.intr_take), 16'h0000);
    wr(INTR_IPR, 16'hFFFF);
    chk_reg("lvl_w1c_ignored", INTR_IPR, 16'h000C);
    chk("lvl_no_nest", 16'(bus.intr_req), 16'h0000);

    // Line still high through rfi: one IDLE cycle, then re-request.
    bus.rfi = 1'b1;
    tick(1);
    bus.rfi = 1'b0;
    chk("lvl_gap", 16'(bus.intr_req), 16'h0000);
    chk_reg("lvl_stat_idle", INTR_STAT, 16'h0020);
    tick(1);
    chk_out("lvl_refire", 1'b1, 1'b0, 4'd2);

    // Withdrawal by clearing IE, then re-issue.
    bus.psr = 16'h0000;
    tick(1);
    chk_out("wd_idle", 1'b0, 1'b0, 4'd2);
    chk_reg("wd_pend_kept", INTR_IPR, 16'h000C);
    bus.psr = 16'h0008;
    tick(1);
    chk_out("wd_reissue", 1'b1, 1'b0, 4'd2);

    // Ack and withdrawal together: ack wins.
    bus.intr_ack = 1'b1;
    bus.psr      = 16'h0000;
    tick(1);
    bus.intr_ack = 1'b0;
    bus.psr      = 16'h0008;
    chk_out("race_ack", 1'b0, 1'b1, 4'd2);
    tick(1);
    chk("race_take_once", 16'(bus.intr_take), 16'h0000);
    irq = 8'h00;
    tick(2);
    bus.rfi = 1'b1;
    tick(1);
    bus.rfi = 1'b0;
    tick(2);
    chk("lvl_dropped_noreq", 16'(bus.intr_req), 16'h0000);

    // Priority: lines 5 and 1 together.
    wr(INTR_IMR, 16'h00FF);
    irq = 8'h22;
    tick(3);
    chk_out("prio_first", 1'b1, 1'b0, 4'd1);
    bus.intr_ack = 1'b1;
    tick(1);
    bus.intr_ack = 1'b0;
    irq = 8'h20;
    tick(2);
    bus.rfi = 1'b1;
    tick(1);
    bus.rfi = 1'b0;
    chk("prio_gap", 16'(bus.intr_req), 16'h0000);
    tick(1);
    chk_out("prio_second", 1'b1, 1'b0, 4'd5);

    // Higher-priority line arriving in REQ does not change the id.
    irq = 8'h21;
    tick(3);
    chk_reg("frozen_pend", INTR_IPR, 16'h0021);
    chk_out("frozen_id", 1'b1, 1'b0, 4'd5);
`endif

    // Accept, then reset while in service.
    bus.intr_ack = 1'b1;
    tick(1);
    bus.intr_ack = 1'b0;
    chk_out("svc_take", 1'b0, 1'b1, 4'd5);
    chk_reg("svc_stat", INTR_STAT, 16'h0052);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk_out("svc_reset", 1'b0, 1'b0, 4'd0);
    chk_reg("svc_reset_imr",  INTR_IMR,  16'h0000);
    chk_reg("svc_reset_stat", INTR_STAT, 16'h0000);
    tick(3);
    chk_out("post_reset", 1'b0, 1'b0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Hardware interrupt controller for the 16-bit core. It sits directly upstream of the control-register file and turns up to 16 asynchronous device interrupt lines into one prioritised request to the core. When the core acknowledges, it emits a one-cycle `intr_take` pulse; this drives the control-register file's exception entry alongside `trap`/`ill_inst`. It also exposes mask, pending and status registers on a small register port.

## Interface
- `NUM_IRQ`, default 8: number of interrupt lines, 1..16.
- `clk` in 1: sole clock.
- `rst_n` in 1: synchronous reset, active-low.
- `irq_in` in NUM_IRQ: asynchronous device lines, active-high.
- `psr` in 16: current PSR; `psr[3]` is the global interrupt enable (IE).
- `rfi` in 1: return-from-interrupt retiring this cycle.
- `intr_ack` in 1: core accepts the request at an instruction boundary.
- `intr_req` out 1: request to the core; high exactly in state REQ.
- `intr_id` out 4: line number of the request or of the interrupt in service.
- `intr_take` out 1: one-cycle pulse on the accept edge; feeds exception entry.
- `reg_wen` in 1: register write strobe.
- `reg_addr` in 2: 0 = IMR, 1 = IPR, 2 = STAT.
- `reg_wdata` in 16: register write data.
- `reg_rdata` out 16: combinational read of `reg_addr`.

## Operation
- Each line passes through a 2-flop synchroniser, giving `sync[i]`.
- **IMR:** read/write; bit i = 1 enables line i; bits ≥ NUM_IRQ read 0.
- **IPR:** pending bits; see Configuration.
- **STAT:** bits [1:0] = state encoding; [7:4] = `intr_id`; other bits 0.
- **Eligible:** `pend & IMR`, gated by `psr[3]`. Priority is fixed: lowest index wins.
- **FSM IDLE:** if eligible is non-zero and IE = 1, latch the winning id and go to REQ.
- **FSM REQ:**
  - `intr_ack` → pulse `intr_take`, clear pending bit `intr_id` (edge mode), go to SVC.
  - Otherwise, if the latched line is no longer eligible or IE = 0 → back to IDLE; the request is withdrawn.
  - Ack and withdrawal in the same cycle: ack wins.
  - `intr_id` stays frozen in REQ, even if a higher-priority line arrives.
- **FSM SVC:** no new request (no nesting). `rfi` → IDLE; `intr_id` is held until then.
- `rfi` in IDLE or REQ is ignored.
- Register writes to IMR and IPR take effect at the next edge. Arbitration always uses registered values.
- A software W1C to IPR and an edge set of the same bit in the same cycle: set wins.
- An ack-clear and a new edge on the same line in the same cycle: set wins.

## Timing
- **Reset** (`rst_n` = 0 at an edge):
  - state = IDLE; IMR = 0; IPR = 0; synchroniser flops = 0; `intr_id` = 0.
  - `intr_req` = 0; `intr_take` = 0.
  - Reset in REQ or SVC aborts without a `intr_take` pulse.
- **Latency, edge mode:** line sampled high at edge E0 gives pending at E2 and `intr_req` high after E3.
- **Latency, level mode:** `intr_req` high after E2.
- **Accept:** `intr_ack` sampled high at edge Ek while in REQ gives `intr_take` high for exactly the cycle after Ek. The state is SVC in that same cycle.
- **Minimum gap:** at least one IDLE cycle separates `rfi` from the next `intr_req`.

## Configuration
- Macro `INTR_EDGE_EN`.
- **Defined:**
  - A rising edge of `sync[i]` sets IPR[i], with a third flop holding the previous value.
  - IPR[i] is cleared on accept, or by writing 1 to IPR[i] (W1C).
- **Undefined:**
  - IPR = `sync` (level). Writes to IPR are ignored.
  - Nothing is cleared on accept; the device must drop its line before `rfi`, or the interrupt re-fires.

## Structure
- Package `intr_pkg`:
  - state enum (IDLE = 0, REQ = 1, SVC = 2);
  - register address constants `INTR_IMR`, `INTR_IPR`, `INTR_STAT`;
  - `PSR_IE_BIT = 3`.
- Sub-module `irq_sync`: parameterised-width 2-flop synchroniser with synchronous active-low reset.
- Priority encoder and FSM live in `intr_ctrl`.

## Test plan
- **Mask and IE gating:** IMR = 0x0004, IE = 1, line 2 pulsed high for 1 cycle (edge mode) → `intr_req` after 3 edges, `intr_id` = 2, STAT = 0x0021.
- **Priority:** lines 5 and 1 rise together, IMR = 0xFF → `intr_id` = 1. Ack → after `rfi`, the next request carries `intr_id` = 5.
- **Withdrawal:** in REQ, the PSR write clears bit 3 before ack → back to IDLE, no `intr_take`, IPR bit still set. Restoring IE → request re-issued.
- **Same-cycle races:** ack plus withdrawal in one cycle → `intr_take` pulses once. W1C plus a new edge on the same bit → IPR bit stays 1.
- **Level mode** (macro undefined): line held high through `rfi` → re-request with the same id. W1C to IPR has no effect.
- **Reset:** `rst_n` low for 1 cycle while in SVC → all outputs 0, IMR = 0, no `intr_take` afterwards.
